// File: rtl/fetch_queue.sv
// Fetch queue between the IF and ID stages.
// A small circular FIFO of {pc, instr} pairs. The head entry is shown to ID
// with zero read latency. A flush (branch/jump redirect) empties the queue on
// the next edge. When the queue is empty, ID sees a NOP together with the PC
// of the entry it consumed last.
module fetch_queue #(
   parameter int unsigned              PC_W      = 32,
   parameter int unsigned              INSTR_W   = 32,
   parameter int unsigned              DEPTH     = 4,
   parameter logic [INSTR_W-1:0]       NOP_INSTR = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush_i,
   input  logic                        in_valid_i,
   input  logic [PC_W-1:0]             in_pc_i,
   input  logic [INSTR_W-1:0]          in_instr_i,
   output logic                        in_ready_o,
   output logic                        out_valid_o,
   output logic [PC_W-1:0]             out_pc_o,
   output logic [INSTR_W-1:0]          out_instr_o,
   input  logic                        out_ready_i,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PC_W-1:0]    last_pc_q, last_pc_d;

   logic               push;
   logic               pop;
   entry_t             head_entry;

   // Handshake flags. in_ready ignores out_ready on purpose: a full queue
   // never accepts, even when ID drains the head the same cycle.
   always_comb begin
      in_ready_o  = (count_q < DEPTH_C);
      out_valid_o = (count_q != '0);
      push        = in_valid_i && in_ready_o && !flush_i;
      pop         = out_valid_o && out_ready_i && !flush_i;
      head_entry  = mem_q[head_q];
   end

   // Output view: the head entry while valid, otherwise a NOP at the last consumed PC.
   always_comb begin
      out_pc_o    = last_pc_q;
      out_instr_o = NOP_INSTR;
      count_o     = count_q;
      if (out_valid_o) begin
         out_pc_o    = head_entry.pc;
         out_instr_o = head_entry.instr;
      end
   end

   // Next-state for the pointers, occupancy and last-popped PC; flush wins over push and pop.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      last_pc_d = last_pc_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) tail_d = tail_q + 1'b1;
         if (pop) begin
            head_d    = head_q + 1'b1;
            last_pc_d = head_entry.pc;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is assigned with <= so every register samples
      // its pre-edge inputs; blocking assignments here would race.
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         last_pc_q <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         last_pc_q <= last_pc_d;
      end
   end

   // Entry storage write at the tail.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; its contents are only ever
      // shown while out_valid is high, so stale data cannot leak out.
      if (push) begin
         mem_q[tail_q] <= '{pc: in_pc_i, instr: in_instr_i};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4, 32-bit PC and instruction, NOP=0).
// Inputs change 1ns after a rising edge; outputs are sampled 2ns after it.
module tb_fetch_queue;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 4;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush_i;
   logic               in_valid_i;
   logic [PC_W-1:0]    in_pc_i;
   logic [INSTR_W-1:0] in_instr_i;
   logic               in_ready_o;
   logic               out_valid_o;
   logic [PC_W-1:0]    out_pc_o;
   logic [INSTR_W-1:0] out_instr_o;
   logic               out_ready_i;
   logic [2:0]         count_o;

   int tests_run    = 0;
   int tests_failed = 0;

   fetch_queue #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_pc_i     (in_pc_i),
      .in_instr_i  (in_instr_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_pc_o    (out_pc_o),
      .out_instr_o (out_instr_o),
      .out_ready_i (out_ready_i),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   // Instruction word paired with each PC, so instr checks are distinct per entry.
   function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   // Advance one rising edge, then settle 1ns before new inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
      in_valid_i  = v;
      in_pc_i     = pc;
      in_instr_i  = instr_of(pc);
      out_ready_i = rdy;
      flush_i     = fl;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      #2;
      tests_run++; if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
      tests_run++; if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_o); end
      tests_run++; if (count_o !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", count_o); end
      tests_run++; if (out_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc got=%h exp=0", out_pc_o); end
      tests_run++; if (out_instr_o !== NOP) begin tests_failed++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr_o, NOP); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   // Three pushes with ID stalled: head stays at 0x100 throughout.
   task automatic test_stall();
      logic [PC_W-1:0] pcs [3];
      pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pcs[i], 1'b0, 1'b0);
         tick();
         #1;
         tests_run++; if (out_pc_o !== 32'h100) begin tests_failed++; $display("FAIL stall_push%0d_out_pc got=%h exp=100", i, out_pc_o); end
         tests_run++; if (count_o !== 3'(i + 1)) begin tests_failed++; $display("FAIL stall_push%0d_count got=%0d exp=%0d", i, count_o, i + 1); end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         tests_run++; if (out_pc_o !== 32'h100 || out_instr_o !== instr_of(32'h100) || out_valid_o !== 1'b1)
            begin tests_failed++; $display("FAIL stall_hold%0d got pc=%h instr=%h v=%0b exp pc=100", i, out_pc_o, out_instr_o, out_valid_o); end
         tests_run++; if (count_o !== 3'd3) begin tests_failed++; $display("FAIL stall_hold%0d_count got=%0d exp=3", i, count_o); end
      end
   endtask

   // Fill to DEPTH, reject extra pushes (with and without a pop), then drain in order.
   task automatic test_full();
      logic [PC_W-1:0] exp_pc [3];
      exp_pc[0] = 32'h200; exp_pc[1] = 32'h300; exp_pc[2] = 32'h400;
      drive(1'b1, 32'h400, 1'b0, 1'b0);
      tick();
      #1;
      tests_run++; if (count_o !== 3'd4) begin tests_failed++; $display("FAIL full_count got=%0d exp=4", count_o); end
      tests_run++; if (in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready got=%0b exp=0", in_ready_o); end
      drive(1'b1, 32'h500, 1'b0, 1'b0);
      tick();
      #1;
      tests_run++; if (count_o !== 3'd4) begin tests_failed++; $display("FAIL full_fifth_push_count got=%0d exp=4", count_o); end
      // Full with ID ready: pop happens, push of 0x600 is refused.
      drive(1'b1, 32'h600, 1'b1, 1'b0);
      tests_run++; if (out_pc_o !== 32'h100) begin tests_failed++; $display("FAIL full_head got=%h exp=100", out_pc_o); end
      tick();
      #1;
      tests_run++; if (count_o !== 3'd3) begin tests_failed++; $display("FAIL full_pop_count got=%0d exp=3", count_o); end
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (out_pc_o !== exp_pc[i] || out_instr_o !== instr_of(exp_pc[i]) || out_valid_o !== 1'b1)
            begin tests_failed++; $display("FAIL drain%0d got pc=%h instr=%h v=%0b exp pc=%h", i, out_pc_o, out_instr_o, out_valid_o, exp_pc[i]); end
         tick();
         #1;
      end
      tests_run++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin tests_failed++; $display("FAIL drain_empty got v=%0b cnt=%0d exp v=0 cnt=0", out_valid_o, count_o); end
      tests_run++; if (out_pc_o !== 32'h400 || out_instr_o !== NOP) begin tests_failed++; $display("FAIL drain_idle got pc=%h instr=%h exp pc=400 instr=%h", out_pc_o, out_instr_o, NOP); end
   endtask

   // Count held at 2 while pushing and popping every cycle for 10 cycles.
   task automatic test_back_to_back();
      drive(1'b1, 32'h1000, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h1004, 1'b0, 1'b0); tick();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h1008 + 32'(4 * k), 1'b1, 1'b0);
         tests_run++; if (out_pc_o !== 32'h1000 + 32'(4 * k) || out_instr_o !== instr_of(32'h1000 + 32'(4 * k)))
            begin tests_failed++; $display("FAIL b2b%0d_out got pc=%h instr=%h exp pc=%h", k, out_pc_o, out_instr_o, 32'h1000 + 32'(4 * k)); end
         tests_run++; if (count_o !== 3'd2) begin tests_failed++; $display("FAIL b2b%0d_count got=%0d exp=2", k, count_o); end
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (count_o !== 3'd2 || out_pc_o !== 32'h1028) begin tests_failed++; $display("FAIL b2b_end got cnt=%0d pc=%h exp cnt=2 pc=1028", count_o, out_pc_o); end
   endtask

   // Flush with a same-cycle push: everything dropped, last-popped PC kept.
   task automatic test_flush();
      drive(1'b0, '0, 1'b1, 1'b0); tick();            // pops 0x1028
      drive(1'b1, 32'h2000, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h2004, 1'b0, 1'b0); tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (count_o !== 3'd3 || out_pc_o !== 32'h102C) begin tests_failed++; $display("FAIL flush_pre got cnt=%0d pc=%h exp cnt=3 pc=102c", count_o, out_pc_o); end
      drive(1'b1, 32'h400, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_empty got cnt=%0d v=%0b exp cnt=0 v=0", count_o, out_valid_o); end
      tests_run++; if (out_instr_o !== NOP || out_pc_o !== 32'h1028) begin tests_failed++; $display("FAIL flush_view got pc=%h instr=%h exp pc=1028 instr=%h", out_pc_o, out_instr_o, NOP); end
      tick();
      tests_run++; if (count_o !== 3'd0) begin tests_failed++; $display("FAIL flush_drop got cnt=%0d exp=0", count_o); end
   endtask

   // Push and pop requested on an empty queue: only the push happens.
   task automatic test_empty_push_pop();
      drive(1'b1, 32'h500, 1'b1, 1'b0);
      tests_run++; if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL epp_pre_valid got=%0b exp=0", out_valid_o); end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (out_valid_o !== 1'b1 || count_o !== 3'd1) begin tests_failed++; $display("FAIL epp_state got v=%0b cnt=%0d exp v=1 cnt=1", out_valid_o, count_o); end
      tests_run++; if (out_pc_o !== 32'h500 || out_instr_o !== instr_of(32'h500)) begin tests_failed++; $display("FAIL epp_out got pc=%h instr=%h exp pc=500", out_pc_o, out_instr_o); end
   endtask

   // Reset raised between edges with two entries queued takes effect at once.
   task automatic test_async_reset();
      drive(1'b1, 32'h504, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (count_o !== 3'd2) begin tests_failed++; $display("FAIL areset_pre got cnt=%0d exp=2", count_o); end
      #1;
      rst = 1'b1;
      #1;
      tests_run++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
         begin tests_failed++; $display("FAIL areset_state got cnt=%0d v=%0b rdy=%0b exp cnt=0 v=0 rdy=1", count_o, out_valid_o, in_ready_o); end
      tests_run++; if (out_pc_o !== 32'h0 || out_instr_o !== NOP) begin tests_failed++; $display("FAIL areset_view got pc=%h instr=%h exp pc=0", out_pc_o, out_instr_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      drive(1'b1, 32'h700, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (count_o !== 3'd1 || out_pc_o !== 32'h700) begin tests_failed++; $display("FAIL areset_after got cnt=%0d pc=%h exp cnt=1 pc=700", count_o, out_pc_o); end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_full();
      test_back_to_back();
      test_flush();
      test_empty_push_pop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
